// File: rtl/piano_voice_allocator.sv
// piano_voice_allocator: synchronizes/debounces eight keys and maps presses onto
// NUM_VOICES shared tone generators, stealing the oldest voice when all are busy.
`default_nettype none

module piano_voice_allocator #(
    parameter int NUM_VOICES      = 4,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              sw,
    output logic [NUM_VOICES-1:0]   voice_en,
    output logic [3*NUM_VOICES-1:0] voice_note,
    output logic                    alloc_full,
    output logic                    steal_pulse
);

    localparam int VIDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [7:0]       sync1, sync2, deb, deb_next;
    logic [CNT_W-1:0] cnt      [8];
    logic [CNT_W-1:0] cnt_next [8];
    logic [7:0]       pend_prs, pend_rel, prs_next, rel_next, rise, fall;
    logic [3:0]       age      [NUM_VOICES];
    logic [3:0]       age_next [NUM_VOICES];

    logic [NUM_VOICES-1:0]   en_next, match;
    logic [3*NUM_VOICES-1:0] note_next;
    logic                    steal_next, svc_valid, is_rel;
    logic [2:0]              rel_key, prs_key, key;
    logic [VIDX_W-1:0]       free_v, old_v, alloc_v;
    logic [3:0]              old_age;

    // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing samples
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            deb_next[k] = deb[k];
            cnt_next[k] = '0;
            if (sync2[k] != deb[k]) begin
                if (cnt[k] == CNT_LAST) deb_next[k] = sync2[k];
                else                    cnt_next[k] = cnt[k] + 1'b1;
            end
        end
        rise = deb_next & ~deb;
        fall = deb & ~deb_next;
    end

    // Pick one pending event: releases before presses, lowest key first
    always_comb begin
        rel_key = '0;
        prs_key = '0;
        for (int k = 7; k >= 0; k--) begin
            if (pend_rel[k]) rel_key = 3'(k);
            if (pend_prs[k]) prs_key = 3'(k);
        end
        is_rel    = |pend_rel;
        svc_valid = is_rel | (|pend_prs);
        key       = is_rel ? rel_key : prs_key;
    end

    // Pending bits: service clears first, then new edges are folded in so an
    // edge arriving as its opposite event is serviced still gets queued.
    always_comb begin
        rel_next = pend_rel;
        prs_next = pend_prs;
        if (svc_valid) begin
            if (is_rel) rel_next[key] = 1'b0;
            else        prs_next[key] = 1'b0;
        end
        for (int k = 0; k < 8; k++) begin
            if (rise[k]) begin
                if (rel_next[k]) rel_next[k] = 1'b0;
                else             prs_next[k] = 1'b1;
            end
            if (fall[k]) begin
                if (prs_next[k]) prs_next[k] = 1'b0;
                else             rel_next[k] = 1'b1;
            end
        end
    end

    // Voice table update
    always_comb begin
        en_next    = voice_en;
        note_next  = voice_note;
        steal_next = 1'b0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            age_next[v] = age[v];
            match[v]    = voice_en[v] && (voice_note[3*v +: 3] == key);
        end
        free_v  = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (!voice_en[v]) free_v = VIDX_W'(v);
        end
        old_v   = '0;
        old_age = age[0];
        for (int v = 1; v < NUM_VOICES; v++) begin
            if (age[v] > old_age) begin
                old_v   = VIDX_W'(v);
                old_age = age[v];
            end
        end
        alloc_v = (&voice_en) ? old_v : free_v;

        if (svc_valid) begin
            if (is_rel) begin
                en_next = voice_en & ~match;
            end else if (match == '0) begin
                steal_next = &voice_en;
                for (int v = 0; v < NUM_VOICES; v++) begin
                    if (v == int'(alloc_v)) begin
                        en_next[v]          = 1'b1;
                        note_next[3*v +: 3] = key;
                        age_next[v]         = 4'd0;
                    end else if (voice_en[v] && age[v] != 4'd15) begin
                        age_next[v] = age[v] + 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1       <= '0;
            sync2       <= '0;
            deb         <= '0;
            pend_prs    <= '0;
            pend_rel    <= '0;
            voice_en    <= '0;
            voice_note  <= '0;
            alloc_full  <= 1'b0;
            steal_pulse <= 1'b0;
            for (int k = 0; k < 8; k++) cnt[k] <= '0;
            for (int v = 0; v < NUM_VOICES; v++) age[v] <= '0;
        end else begin
            sync1       <= sw;
            sync2       <= sync1;
            deb         <= deb_next;
            pend_prs    <= prs_next;
            pend_rel    <= rel_next;
            voice_en    <= en_next;
            voice_note  <= note_next;
            alloc_full  <= &en_next;
            steal_pulse <= steal_next;
            for (int k = 0; k < 8; k++) cnt[k] <= cnt_next[k];
            for (int v = 0; v < NUM_VOICES; v++) age[v] <= age_next[v];
        end
    end

endmodule

`default_nettype wire
